// File: rtl/lock_in_polar_converter.sv
// lock_in_polar_converter: iterative vectoring CORDIC turning lock-in (x, y) into amplitude and phase
module lock_in_polar_converter #(
   parameter int NUM_BITS   = 24,
   parameter int PHASE_BITS = 24,
   parameter int NUM_ITER   = 16
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         tick_i,
   input  logic signed [NUM_BITS-1:0]   x_i,
   input  logic signed [NUM_BITS-1:0]   y_i,
   output logic signed [NUM_BITS-1:0]   ampl_o,
   output logic signed [PHASE_BITS-1:0] phase_o,
   output logic                         done_o,
   output logic                         busy_o,
   output logic                         overrun_o
);
   localparam int XW = NUM_BITS + 2;
   localparam int ZW = PHASE_BITS + 1;
   localparam int PW = XW + 24;
   localparam int CW = $clog2(NUM_ITER + 1);
   localparam logic [CW-1:0] LAST = CW'(NUM_ITER - 1);
   localparam logic signed [23:0] K = 24'sd5094007;
   localparam logic signed [ZW-1:0] PI = {2'b01, {(PHASE_BITS-1){1'b0}}};
   localparam logic signed [NUM_BITS-1:0] MAXA = {1'b0, {(NUM_BITS-1){1'b1}}};

   typedef enum logic [1:0] {IDLE, ITER, SCALE} st_t;

   // atan(2^-i) in units where 2^23 is pi
   function automatic logic signed [ZW-1:0] atan_lut(input int i);
      case (i)
         0: return ZW'(2097152);
         1: return ZW'(1238021);
         2: return ZW'(654136);
         3: return ZW'(332050);
         4: return ZW'(166669);
         5: return ZW'(83415);
         6: return ZW'(41718);
         7: return ZW'(20860);
         8: return ZW'(10430);
         9: return ZW'(5215);
         10: return ZW'(2608);
         11: return ZW'(1304);
         12: return ZW'(652);
         13: return ZW'(326);
         14: return ZW'(163);
         15: return ZW'(81);
         16: return ZW'(41);
         17: return ZW'(20);
         18: return ZW'(10);
         19: return ZW'(5);
         20: return ZW'(3);
         21: return ZW'(1);
         22: return ZW'(1);
         default: return '0;
      endcase
   endfunction

   st_t                         state_q, state_d;
   logic signed [XW-1:0]        x_q, x_d, y_q, y_d, xe, ye, xs, ys;
   logic signed [ZW-1:0]        z_q, z_d, lut;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic signed [NUM_BITS-1:0]  ampl_q, ampl_d;
   logic signed [PHASE_BITS-1:0] phase_q, phase_d;
   logic                        done_q, done_d, ovr_q, ovr_d, zero_q, zero_d;
   logic signed [PW-1:0]        prod;

   assign xe = XW'(x_i);
   assign ye = XW'(y_i);
   assign xs = x_q >>> cnt_q;
   assign ys = y_q >>> cnt_q;
   assign lut = atan_lut(int'(cnt_q));
   assign prod = (x_q * K) >>> 23;
   assign ampl_o = ampl_q;
   assign phase_o = phase_q;
   assign done_o = done_q;
   assign overrun_o = ovr_q;

   // state register
   always_ff @(posedge clk_i)
      state_q <= reset_i ? IDLE : state_d;

   // sequencing: accept a tick in IDLE, run NUM_ITER rotations, one scaling cycle
   always_comb
      state_d = state_q == IDLE ? (tick_i ? ITER : IDLE) :
                state_q == ITER ? (cnt_q == LAST ? SCALE : ITER) : IDLE;

   // busy covers the rotation and scaling cycles only
   always_comb
      busy_o = state_q != IDLE;

   // datapath: pre-rotation into the right half-plane, micro-rotations, gain removal
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      z_d = z_q;
      cnt_d = cnt_q;
      zero_d = zero_q;
      ampl_d = ampl_q;
      phase_d = phase_q;
      done_d = state_q == SCALE;
      ovr_d = ovr_q | (tick_i & (state_q != IDLE));
      if (state_q == IDLE && tick_i) begin
         x_d = x_i[NUM_BITS-1] ? -xe : xe;
         y_d = x_i[NUM_BITS-1] ? -ye : ye;
         z_d = !x_i[NUM_BITS-1] ? '0 : y_i[NUM_BITS-1] ? -PI : PI;
         cnt_d = '0;
         zero_d = x_i == '0 && y_i == '0;
      end else if (state_q == ITER) begin
         x_d = y_q[XW-1] ? x_q - ys : x_q + ys;
         y_d = y_q[XW-1] ? y_q + xs : y_q - xs;
         z_d = y_q[XW-1] ? z_q - lut : z_q + lut;
         cnt_d = cnt_q + 1'b1;
      end else if (state_q == SCALE) begin
         ampl_d = prod[PW-1] ? '0 : prod > PW'(MAXA) ? MAXA : prod[NUM_BITS-1:0];
         phase_d = zero_q ? '0 : z_q[PHASE_BITS-1:0];
      end
   end

   // datapath registers, cleared by reset including mid-conversion
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         x_q <= '0;
         y_q <= '0;
         z_q <= '0;
         cnt_q <= '0;
         zero_q <= 1'b0;
         ampl_q <= '0;
         phase_q <= '0;
         done_q <= 1'b0;
         ovr_q <= 1'b0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
         z_q <= z_d;
         cnt_q <= cnt_d;
         zero_q <= zero_d;
         ampl_q <= ampl_d;
         phase_q <= phase_d;
         done_q <= done_d;
         ovr_q <= ovr_d;
      end
   end
endmodule

// File: tb/tb_lock_in_polar_converter.sv
// tb_lock_in_polar_converter: directed checks of latency, accuracy, wrap, saturation, overrun and reset
module tb_lock_in_polar_converter;
   logic clk = 1'b0;
   logic reset_i = 1'b1;
   logic tick_i = 1'b0;
   logic signed [23:0] x_i = '0, y_i = '0;
   logic signed [23:0] ampl_o, phase_o;
   logic done_o, busy_o, overrun_o;
   int checks = 0;
   int errors = 0;
   int n, b, dn;
   logic signed [23:0] held;

   lock_in_polar_converter dut (
      .clk_i(clk), .reset_i(reset_i), .tick_i(tick_i), .x_i(x_i), .y_i(y_i),
      .ampl_o(ampl_o), .phase_o(phase_o), .done_o(done_o), .busy_o(busy_o), .overrun_o(overrun_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // tolerance compare with 24-bit wrap, so +pi and -pi are neighbours
   task automatic chk_tol(input string tag, input logic signed [23:0] got, input logic signed [23:0] exp, input int tol);
      logic signed [23:0] d;
      d = got - exp;
      checks++;
      assert (d >= -tol && d <= tol) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, got, exp, tol);
      end
   endtask

   task automatic start(input logic signed [23:0] x, input logic signed [23:0] y);
      x_i = x;
      y_i = y;
      tick_i = 1'b1;
      @(negedge clk);
      tick_i = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output int bz);
      cyc = 0;
      bz = 0;
      while (!done_o && cyc < 100) begin
         if (busy_o) bz++;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic count_done(input int cyc, output int cnt);
      cnt = 0;
      for (int i = 0; i < cyc; i++) begin
         @(negedge clk);
         if (done_o) cnt++;
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset_i = 1'b0;
      chk("rst_ampl", ampl_o, 0);
      chk("rst_phase", phase_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_ovr", overrun_o, 0);

      start(24'sd4194304, 24'sd0);
      wait_done(n, b);
      chk("lat_pos_x", n, 17);
      chk("busy_len", b, 17);
      chk("busy_at_done", busy_o, 0);
      chk_tol("ampl_pos_x", ampl_o, 24'sd4194304, 32);
      chk_tol("phase_pos_x", phase_o, 24'sd0, 128);
      held = ampl_o;
      @(negedge clk);
      chk("done_width", done_o, 0);
      repeat (3) @(negedge clk);
      chk("ampl_hold", ampl_o, held);

      start(24'sd0, 24'sd4194304);
      wait_done(n, b);
      chk_tol("ampl_pos_y", ampl_o, 24'sd4194304, 32);
      chk_tol("phase_pos_y", phase_o, 24'sd4194304, 128);
      start(24'sd0, -24'sd4194304);
      wait_done(n, b);
      chk("lat_b2b", n, 17);
      chk_tol("ampl_neg_y", ampl_o, 24'sd4194304, 32);
      chk_tol("phase_neg_y", phase_o, -24'sd4194304, 128);

      @(negedge clk);
      start(-24'sd4194304, 24'sd0);
      wait_done(n, b);
      chk_tol("ampl_neg_x", ampl_o, 24'sd4194304, 32);
      chk_tol("phase_neg_x", phase_o, -24'sd8388608, 128);
      @(negedge clk);
      start(-24'sd4194304, -24'sd1);
      wait_done(n, b);
      chk_tol("phase_neg_x_y1", phase_o, -24'sd8388608, 128);
      @(negedge clk);
      start(-24'sd8388608, -24'sd8388608);
      wait_done(n, b);
      chk("ampl_sat", ampl_o, 8388607);
      chk_tol("phase_3q", phase_o, -24'sd6291456, 128);
      chk("ovr_clear", overrun_o, 0);

      @(negedge clk);
      start(24'sd4194304, 24'sd0);
      repeat (4) @(negedge clk);
      start(-24'sd8388608, 24'sd123);
      repeat (11) @(negedge clk);
      chk("scale_busy", busy_o, 1);
      start(24'sd0, 24'sd4194304);
      chk("ovr_done", done_o, 1);
      chk_tol("ovr_ampl", ampl_o, 24'sd4194304, 32);
      chk_tol("ovr_phase", phase_o, 24'sd0, 128);
      @(negedge clk);
      chk("ovr_idle", busy_o, 0);
      chk("ovr_flag", overrun_o, 1);
      count_done(25, dn);
      chk("ovr_single_done", dn, 0);
      chk("ovr_sticky", overrun_o, 1);

      start(24'sd0, 24'sd4194304);
      repeat (7) @(negedge clk);
      reset_i = 1'b1;
      @(negedge clk);
      reset_i = 1'b0;
      chk("mid_ampl", ampl_o, 0);
      chk("mid_phase", phase_o, 0);
      chk("mid_done", done_o, 0);
      chk("mid_busy", busy_o, 0);
      chk("mid_ovr", overrun_o, 0);
      count_done(30, dn);
      chk("mid_no_done", dn, 0);
      start(24'sd0, 24'sd0);
      wait_done(n, b);
      chk("lat_zero", n, 17);
      chk("zero_ampl", ampl_o, 0);
      chk("zero_phase", phase_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/lock_in_polar_converter.md
Name: lock_in_polar_converter

Overview:
- Downstream stage of the lock-in amplifier.
- Consumes each filtered in-phase/quadrature pair (x, y) when the amplifier's done_o strobe fires, and converts it to amplitude and phase with an iterative, vectoring-mode CORDIC (one micro-rotation per clock).
- Results feed the metrology/control path. It replaces any software-side atan2/sqrt.

Parameters:
- NUM_BITS, 24, width of x_i/y_i/ampl_o (signed two's complement).
- PHASE_BITS, 24, width of phase_o; full scale ±2^(PHASE_BITS-1) represents ±pi.
- NUM_ITER, 16, number of CORDIC micro-rotations (1..PHASE_BITS-1).

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- tick_i  in  1  one-cycle strobe: x_i/y_i valid (driven by lock-in done_o).
- x_i  in  NUM_BITS  signed in-phase component.
- y_i  in  NUM_BITS  signed quadrature component.
- ampl_o  out  NUM_BITS  signed, always >= 0; sqrt(x^2+y^2), same scale as inputs.
- phase_o  out  PHASE_BITS  signed; atan2(y, x) scaled so 2^(PHASE_BITS-1) = pi.
- done_o  out  1  one-cycle pulse: ampl_o/phase_o updated.
- busy_o  out  1  high while a conversion is in flight.
- overrun_o  out  1  sticky: a tick_i arrived while busy.

Behaviour:
- Reset: ampl_o=0, phase_o=0, done_o=0, busy_o=0, overrun_o=0, state=IDLE, iteration counter=0.
  - Reset mid-conversion aborts it. No done_o is issued and outputs return to 0.
- States: IDLE -> ITER -> SCALE -> IDLE.
- IDLE: on tick_i, capture and pre-rotate into internal x, y, z, then go to ITER. The counter is i=0.
  - x_i >= 0: x=x_i, y=y_i, z=0.
  - x_i < 0 and y_i >= 0: x=-x_i, y=-y_i, z=+pi.
  - x_i < 0 and y_i < 0: x=-x_i, y=-y_i, z=-pi.
- Internal widths:
  - x/y use NUM_BITS+2 signed bits (covers sqrt2 × CORDIC gain 1.6468; no overflow, -(-2^(NUM_BITS-1)) representable).
  - z uses PHASE_BITS+1 signed bits.
- ITER: one micro-rotation per clock.
  - d = (y >= 0) ? -1 : +1.
  - x' = x - d·(y >>> i).
  - y' = y + d·(x >>> i).
  - z' = z - d·atan_lut[i].
  - Arithmetic right shift (floor).
  - atan_lut[i] = round(atan(2^-i)/pi × 2^(PHASE_BITS-1)) is a constant ROM, e.g. i=0: 2097152.
  - After NUM_ITER cycles go to SCALE.
- SCALE (1 cycle):
  - ampl = (x × K) >>> 23, with K = 5094007 (round(0.607252935 × 2^23)), truncated. Saturate to 2^(NUM_BITS-1)-1 if larger.
  - phase_o = z modulo 2^PHASE_BITS (wrap), so exactly +pi is reported as -2^(PHASE_BITS-1).
  - Register ampl_o and phase_o, and pulse done_o for exactly one cycle. Return to IDLE.
- Latency: tick_i sampled at edge k causes done_o to be high during the cycle following edge k+NUM_ITER+1. That is NUM_ITER+1 clocks (17 at default).
- Throughput: one conversion per NUM_ITER+2 clocks. The audio-rate lock-in tick is far slower.
- busy_o is high in ITER and SCALE. It is low in IDLE, including the cycle in which done_o is high.
- tick_i while busy (including during SCALE) is ignored. The conversion in flight is unaffected, and overrun_o is set until reset.
- tick_i in IDLE in the same cycle as done_o is accepted normally.
- ampl_o/phase_o hold their values between done_o pulses.
- x_i = y_i = 0 yields ampl_o=0, phase_o=0.
- Accuracy at default parameters:
  - |phase error| <= 128 LSB.
  - |amplitude error| <= 32 LSB, away from saturation.

Test Plan:
- Tick with x_i=4194304, y_i=0 -> done_o exactly 17 clocks later, one cycle wide; ampl_o=4194304±32; phase_o=0±128; busy_o high 17 cycles.
- x_i=0, y_i=4194304 -> ampl_o=4194304±32, phase_o=4194304±128 (pi/2). Then x_i=0, y_i=-4194304 -> phase_o=-4194304±128.
- x_i=-4194304, y_i=0 -> phase_o=-8388608 (or +8388607 within tolerance, via wrap); ampl_o=4194304±32. Then x_i=-4194304, y_i=-1 -> phase_o near -8388608.
- x_i=-8388608, y_i=-8388608 -> ampl_o=8388607 (saturated), phase_o=-6291456±128 (-3pi/4).
- Ticks at 5 clocks and at the SCALE cycle after the first tick -> both ignored; a single done_o; results match the first input; overrun_o=1 until reset_i.
- reset_i asserted 8 clocks into a conversion -> no done_o; all outputs 0 next cycle. A following tick with x_i=y_i=0 -> ampl_o=0, phase_o=0.
